seg_scan_ctrl: RTL and testbench

Scan scheduler for the 8-digit multiplexed 7-segment display. It owns the per-digit time slot, inserts anti-ghosting dead time between digits, applies PWM brightness within each slot and performs leading-zero blanking. It double-buffers a 32-bit BCD frame loaded over a valid/ready handshake, so the display never tears. It feeds the existing 7-segment decoder (digit_bcd, seg_blank) and drives the active-low cathodes directly.

---
 rtl/seg_scan_pkg.sv | 12 +
 rtl/seg_lz_mask.sv | 21 ++
 rtl/seg_scan_ctrl.sv | 104 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the 8-digit 7-segment scan controller.
// Imported by the scan scheduler and its leading-zero mask helper.
package seg_scan_pkg;
    localparam int NUM_DIGITS = 8;
    localparam int BCD_W = 4;
    localparam logic [7:0] CATHODE_OFF = 8'hFF;

    typedef enum logic {
        SCAN_DEAD,
        SCAN_ON
    } scan_state_t;
endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero mask: bit i set when nibbles i..7 of the frame are all zero.
// Digit 0 is never marked, so a zero frame still shows a single 0.
module seg_lz_mask
    import seg_scan_pkg::*;
(
    input  logic [NUM_DIGITS*BCD_W-1:0] frame,
    output logic [NUM_DIGITS-1:0]       mask
);

    logic run;

    always_comb begin
        mask = '0;
        run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run = run & (frame[i*BCD_W +: BCD_W] == 4'd0);
            mask[i] = run;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit scan scheduler: slot timing, dead time, PWM brightness, leading-zero
// blanking and a double-buffered BCD frame loaded over valid/ready.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int SLOT_CYCLES = 8192,
    parameter int DEAD_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] frame_data,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [3:0]  brightness,
    input  logic        lz_blank_en,
    output logic [3:0]  digit_bcd,
    output logic        seg_blank,
    output logic [7:0]  seg_cathode,
    output logic        frame_start
);

    localparam int CW = $clog2(SLOT_CYCLES);

    logic [CW-1:0] slot_cnt;
    logic [CW-1:0] slot_next;
    logic [2:0]    digit_idx;
    scan_state_t   state;
    scan_state_t   state_next;
    logic [31:0]   active;
    logic [31:0]   pend_buf;
    logic          pend;
    logic [7:0]    zmask;
    logic [7:0]    zmask_next;
    logic          wrap;
    logic          boundary;
    logic          xfer;
    logic          lit;

    assign slot_next = slot_cnt + CW'(1);
    assign wrap      = (slot_cnt == CW'(SLOT_CYCLES - 1));
    assign boundary  = wrap && (digit_idx == 3'd7);
    assign xfer      = frame_valid && frame_ready;

    // Mask is computed from the frame about to become active, then latched.
    seg_lz_mask u_lz_mask (
        .frame (pend_buf),
        .mask  (zmask_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SCAN_DEAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            SCAN_DEAD: if (slot_next == CW'(DEAD_CYCLES)) state_next = SCAN_ON;
            SCAN_ON:   if (wrap) state_next = SCAN_DEAD;
        endcase
    end

    assign lit = (state == SCAN_ON)
              && (slot_cnt[CW-1 -: 4] < brightness)
              && !(lz_blank_en && zmask[digit_idx]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            digit_idx   <= '0;
            active      <= '0;
            pend_buf    <= '0;
            pend        <= 1'b0;
            zmask       <= 8'hFE;
            frame_ready <= 1'b0;
            seg_cathode <= CATHODE_OFF;
            seg_blank   <= 1'b1;
            digit_bcd   <= '0;
            frame_start <= 1'b0;
        end else begin
            slot_cnt <= slot_next;
            if (wrap) digit_idx <= digit_idx + 3'd1;
            if (boundary && pend) begin
                active <= pend_buf;
                zmask  <= zmask_next;
            end
            if (xfer) begin
                pend_buf <= frame_data;
                pend     <= 1'b1;
            end else if (boundary) begin
                pend <= 1'b0;
            end
            frame_ready <= ~(xfer | (pend & ~boundary));
            seg_cathode <= lit ? ~(8'b1 << digit_idx) : CATHODE_OFF;
            seg_blank   <= ~lit;
            digit_bcd   <= active[digit_idx*BCD_W +: BCD_W];
            frame_start <= (slot_cnt == '0) && (digit_idx == 3'd0);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (SLOT_CYCLES=64, DEAD_CYCLES=4).
// Expected outputs come from a frame-position model of the display schedule.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [3:0]  brightness;
    logic        lz_blank_en;
    logic [3:0]  digit_bcd;
    logic        seg_blank;
    logic [7:0]  seg_cathode;
    logic        frame_start;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.SLOT_CYCLES(64), .DEAD_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .brightness  (brightness),
        .lz_blank_en (lz_blank_en),
        .digit_bcd   (digit_bcd),
        .seg_blank   (seg_blank),
        .seg_cathode (seg_cathode),
        .frame_start (frame_start)
    );

    wire [14:0] obs = {seg_cathode, seg_blank, digit_bcd, frame_start, frame_ready};
    logic [14:0] expv;

    int n_tests = 0;
    int n_fail = 0;

    // Model: m_n = clock edges since reset released; frame position = m_n mod 512.
    int          m_n;
    logic [31:0] m_act;
    logic [31:0] m_pdata;
    bit          m_pend;
    bit          m_ready;

    function automatic bit lz_hides(input logic [31:0] f, input int d);
        return (d != 0) && ((f >> (4 * d)) == 32'd0);
    endfunction

    task automatic tick();
        logic r, v, lz;
        logic [31:0] dat;
        logic [3:0] br;
        logic [7:0] e_cath;
        logic e_blank, e_fs;
        logic [3:0] e_bcd;
        int p, s, d;
        bit on;
        r = rst_n; v = frame_valid; lz = lz_blank_en;
        dat = frame_data; br = brightness;
        @(posedge clk);
        if (!r) begin
            m_n = 0; m_act = '0; m_pdata = '0; m_pend = 0; m_ready = 0;
            e_cath = 8'hFF; e_blank = 1'b1; e_bcd = '0; e_fs = 1'b0;
        end else begin
            p = m_n % 512;
            s = p % 64;
            d = p / 64;
            on = (s >= 4) && ((s / 4) < br) && !(lz && lz_hides(m_act, d));
            e_cath = on ? ~(8'h01 << d) : 8'hFF;
            e_blank = !on;
            e_bcd = m_act[4*d +: 4];
            e_fs = (p == 0);
            if (p == 511 && m_pend) begin
                m_act = m_pdata;
                m_pend = 0;
            end
            if (v && m_ready) begin
                m_pdata = dat;
                m_pend = 1;
            end
            m_ready = !m_pend;
            m_n++;
        end
        expv = {e_cath, e_blank, e_bcd, e_fs, m_ready};
        #1;
    endtask

    // Advance until the outputs show frame position p (always at least one edge).
    task automatic skip_to(input int p);
        do tick(); while (((m_n - 1) % 512) != p);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_valid = 1'b1; frame_data = $urandom;
        brightness = 4'd15; lz_blank_en = 1'b0;
        repeat (3) begin
            tick();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL reset_hold got=%h exp=%h", obs, expv);
            end
        end
        n_tests++;
        if (seg_cathode !== 8'hFF || seg_blank !== 1'b1 || frame_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals cath=%h blank=%b ready=%b exp FF/1/0",
                     seg_cathode, seg_blank, frame_ready);
        end
        rst_n = 1'b1; frame_valid = 1'b0;
        tick();
        n_tests++;
        if (frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_rise got=%b exp=1", frame_ready);
        end
        repeat (4) begin
            tick();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL reset_release cyc=%0d got=%h exp=%h", m_n, obs, expv);
            end
        end
        n_tests++;
        if (seg_cathode !== 8'hFE) begin
            n_fail++;
            $display("FAIL first_lit got=%h exp=fe", seg_cathode);
        end
    endtask

    task automatic test_load();
        skip_to(100);
        frame_data = 32'h12345678; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        n_tests++;
        if (frame_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_ready_low got=%b exp=0", frame_ready);
        end
        do begin
            tick();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL load_wait cyc=%0d got=%h exp=%h", m_n, obs, expv);
            end
        end while (((m_n - 1) % 512) != 0);
        n_tests++;
        if (frame_start !== 1'b1 || digit_bcd !== 4'h8 || frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_swap fs=%b bcd=%h ready=%b exp 1/8/1",
                     frame_start, digit_bcd, frame_ready);
        end
        skip_to(7 * 64 + 10);
        n_tests++;
        if (digit_bcd !== 4'h1) begin
            n_fail++;
            $display("FAIL load_digit7 got=%h exp=1", digit_bcd);
        end
    endtask

    task automatic test_lz_blank();
        int hi_lit = 0, bad = 0, d1_lit = 0;
        lz_blank_en = 1'b1; brightness = 4'd15;
        frame_data = 32'h00000507; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        skip_to(0);
        repeat (511) begin
            tick();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL lz_frame cyc=%0d got=%h exp=%h", m_n, obs, expv);
            end
            if (seg_cathode[7:3] !== 5'h1F) hi_lit++;
            if (seg_cathode === 8'hFB && digit_bcd !== 4'h5) bad++;
            if (seg_cathode === 8'hFE && digit_bcd !== 4'h7) bad++;
            if (seg_cathode === 8'hFD) d1_lit++;
        end
        n_tests++;
        if (hi_lit != 0 || bad != 0 || d1_lit == 0) begin
            n_fail++;
            $display("FAIL lz_digits hi_lit=%0d bad=%0d d1_lit=%0d exp 0/0/>0",
                     hi_lit, bad, d1_lit);
        end
    endtask

    task automatic test_zero_frame();
        int early = 0, d3 = 0, late = 0;
        lz_blank_en = 1'b1; brightness = 4'd15;
        frame_data = 32'h0; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        skip_to(0);
        do begin
            tick();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL zero_early cyc=%0d got=%h exp=%h", m_n, obs, expv);
            end
            if (seg_cathode !== 8'hFF && seg_cathode !== 8'hFE) early++;
        end while (((m_n - 1) % 512) != 3 * 64 + 62);
        lz_blank_en = 1'b0;
        do begin
            tick();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL zero_late cyc=%0d got=%h exp=%h", m_n, obs, expv);
            end
            if (seg_cathode === 8'hF7) d3++;
            if (seg_cathode[7:4] !== 4'hF) late++;
        end while (((m_n - 1) % 512) != 511);
        n_tests++;
        if (early != 0 || d3 != 0 || late == 0) begin
            n_fail++;
            $display("FAIL zero_toggle early=%0d d3=%0d late=%0d exp 0/0/>0",
                     early, d3, late);
        end
    endtask

    task automatic test_brightness();
        int on_cnt = 0;
        lz_blank_en = 1'b0; brightness = 4'd0;
        frame_data = 32'h87654321; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        repeat (512) begin
            tick();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL bri0 cyc=%0d got=%h exp=%h", m_n, obs, expv);
            end
            if (seg_cathode !== 8'hFF) on_cnt++;
        end
        n_tests++;
        if (on_cnt != 0) begin
            n_fail++;
            $display("FAIL bri0_dark lit=%0d exp=0", on_cnt);
        end
        brightness = 4'd8;
        skip_to(63);
        on_cnt = 0;
        repeat (64) begin
            tick();
            if (seg_cathode === 8'hFD) on_cnt++;
        end
        n_tests++;
        if (on_cnt != 28) begin
            n_fail++;
            $display("FAIL bri8_duty lit=%0d exp=28", on_cnt);
        end
        for (int k = 0; k < 8; k++) begin
            brightness = 4'($urandom_range(0, 15));
            repeat (64) begin
                tick();
                n_tests++;
                if (obs !== expv) begin
                    n_fail++;
                    $display("FAIL bri_rand cyc=%0d got=%h exp=%h", m_n, obs, expv);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, c;
        a = {$urandom, 4'h1} >> 0;
        a[3:0] = 4'h1;
        c = $urandom;
        c[3:0] = 4'h2;
        brightness = 4'd15; lz_blank_en = 1'b0;
        skip_to(10);
        frame_data = a; frame_valid = 1'b1;
        tick();
        frame_data = $urandom;
        repeat (10) begin
            tick();
            n_tests++;
            if (obs !== expv || frame_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_hold cyc=%0d got=%h exp=%h", m_n, obs, expv);
            end
        end
        frame_valid = 1'b0;
        skip_to(0);
        n_tests++;
        if (digit_bcd !== 4'h1) begin
            n_fail++;
            $display("FAIL b2b_first got=%h exp=1", digit_bcd);
        end
        skip_to(510);
        frame_data = c; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        tick();
        n_tests++;
        if (obs !== expv || digit_bcd !== 4'h1 || frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_edge got=%h exp=%h", obs, expv);
        end
        skip_to(0);
        n_tests++;
        if (digit_bcd !== 4'h2) begin
            n_fail++;
            $display("FAIL b2b_late got=%h exp=2", digit_bcd);
        end
        skip_to(20);
        frame_data = 32'h99999999; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0; rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (600) begin
            tick();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL rst_pend cyc=%0d got=%h exp=%h", m_n, obs, expv);
            end
        end
        skip_to(0);
        n_tests++;
        if (digit_bcd !== 4'h0 || frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_discard bcd=%h ready=%b exp 0/1", digit_bcd, frame_ready);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            frame_valid = ($urandom % 4) == 0;
            frame_data = $urandom >> ($urandom % 32);
            if ($urandom % 50 == 0) brightness = 4'($urandom_range(0, 15));
            if ($urandom % 70 == 0) lz_blank_en = 1'($urandom % 2);
            tick();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h exp=%h", m_n, obs, expv);
            end
        end
        frame_valid = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        m_n = 0; m_act = '0; m_pdata = '0; m_pend = 0; m_ready = 0;
        expv = '0;
        rst_n = 1'b0; frame_valid = 1'b0; frame_data = '0;
        brightness = '0; lz_blank_en = 1'b0;
        test_reset();
        test_load();
        test_lz_blank();
        test_zero_frame();
        test_brightness();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
